// File: rtl/pll_lock_rst_gen.sv
// pll_lock_rst_gen: PLL reset sequencer and lock supervisor on the reference clock (rev 1.0).
// Define PLL_LOSS_CNT_EN to build the saturating RUN-to-PLLRST lock-loss counter.
`default_nettype none

module pll_lock_rst_gen #(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int STABLE_CYCLES  = 1024,
  parameter int RETRY_MAX      = 7
) (
  input  logic       refclk,
  input  logic       reset,
  input  logic       extlock,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       locked,
  output logic       fault,
  output logic [7:0] lock_loss_cnt
);

  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
  localparam int MAX_ABC = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
  localparam int MAX_P   = (MAX_ABC > RETRY_MAX) ? MAX_ABC : RETRY_MAX;
  localparam int CNT_W   = (MAX_P > 2) ? $clog2(MAX_P) : 1;
  localparam int RTY_W   = $clog2(RETRY_MAX + 2);

  localparam logic [CNT_W-1:0] PLLRST_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RTY_W-1:0] RETRY_LIM    = RTY_W'(RETRY_MAX);
  localparam logic [RTY_W-1:0] RETRY_SAT    = RTY_W'(RETRY_MAX + 1);

  localparam logic [1:0] ST_PLLRST   = 2'd0;
  localparam logic [1:0] ST_WAITLOCK = 2'd1;
  localparam logic [1:0] ST_STABLE   = 2'd2;
  localparam logic [1:0] ST_RUN      = 2'd3;

  logic [1:0]       sync_q;
  logic             lock_s;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             loss_evt;
  logic             pll_rst_q, sys_rst_q, locked_q, fault_q;

  assign lock_s = sync_q[1];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CNT_W'(1);
    retry_d  = retry_q;
    loss_evt = 1'b0;
    case (state_q)
      ST_PLLRST: begin
        if (cnt_q == PLLRST_LAST) begin
          state_d = ST_WAITLOCK;
          cnt_d   = '0;
        end
      end
      ST_WAITLOCK: begin
        // Lock takes priority over a coincident timeout.
        if (lock_s) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == TIMEOUT_LAST) begin
          state_d = ST_PLLRST;
          cnt_d   = '0;
          if (retry_q != RETRY_SAT) retry_d = retry_q + RTY_W'(1);
        end
      end
      ST_STABLE: begin
        if (!lock_s) begin
          state_d = ST_WAITLOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q;
        if (!lock_s) begin
          state_d  = ST_PLLRST;
          cnt_d    = '0;
          loss_evt = 1'b1;
        end
      end
      default: begin
        state_d = ST_PLLRST;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the current state, adding one edge of latency.
  always_ff @(posedge refclk) begin
    if (reset) begin
      sync_q    <= 2'b00;
      state_q   <= ST_PLLRST;
      cnt_q     <= '0;
      retry_q   <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      locked_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], extlock};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      pll_rst_q <= (state_q == ST_PLLRST);
      sys_rst_q <= (state_q != ST_RUN);
      locked_q  <= (state_q == ST_RUN);
      fault_q   <= fault_q | (retry_d > RETRY_LIM);
    end
  end

  assign pll_rst = pll_rst_q;
  assign sys_rst = sys_rst_q;
  assign locked  = locked_q;
  assign fault   = fault_q;

`ifdef PLL_LOSS_CNT_EN
  logic [7:0] loss_q;

  always_ff @(posedge refclk) begin
    if (reset) begin
      loss_q <= 8'd0;
    end else if (loss_evt && (loss_q != 8'hFF)) begin
      loss_q <= loss_q + 8'd1;
    end
  end

  assign lock_loss_cnt = loss_q;
`else
  logic unused_loss_evt;
  assign unused_loss_evt = loss_evt;
  assign lock_loss_cnt   = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_rst_gen.sv
// tb_pll_lock_rst_gen: scoreboard bench for pll_lock_rst_gen against a timing-rule reference model.
`default_nettype none

module tb_pll_lock_rst_gen;

  localparam int P_RST  = 4;
  localparam int P_TO   = 20;
  localparam int P_STB  = 8;
  localparam int P_RMAX = 2;
`ifdef PLL_LOSS_CNT_EN
  localparam bit LOSS_EN = 1'b1;
`else
  localparam bit LOSS_EN = 1'b0;
`endif

  localparam int PH_RESET  = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_STABLE = 2;
  localparam int PH_RUN    = 3;

  logic       refclk = 1'b0;
  logic       reset;
  logic       extlock;
  logic       pll_rst, sys_rst, locked, fault;
  logic [7:0] lock_loss_cnt;

  pll_lock_rst_gen #(
    .PLL_RST_CYCLES(P_RST),
    .LOCK_TIMEOUT  (P_TO),
    .STABLE_CYCLES (P_STB),
    .RETRY_MAX     (P_RMAX)
  ) dut (
    .refclk       (refclk),
    .reset        (reset),
    .extlock      (extlock),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .locked       (locked),
    .fault        (fault),
    .lock_loss_cnt(lock_loss_cnt)
  );

  always #10 refclk = ~refclk;

  typedef struct packed {
    logic       pll;
    logic       sys;
    logic       lck;
    logic       flt;
    logic [7:0] loss;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   edge_no  = 0;
  bit   drv_done = 1'b0;

  // Reference model: lock history as a 2-deep delay line, plus time spent in each phase.
  bit m_hist[$];
  int m_phase, m_time, m_retries, m_losses;
  bit m_fault, m_pll, m_sys, m_lck;

  task automatic go(input int ph);
    m_phase = ph;
    m_time  = 0;
  endtask

  task automatic model_edge(input bit r, input bit e);
    exp_t x;
    bit   ls;
    if (r) begin
      m_hist    = '{1'b0, 1'b0};
      m_phase   = PH_RESET;
      m_time    = 0;
      m_retries = 0;
      m_losses  = 0;
      m_fault   = 1'b0;
      m_pll     = 1'b1;
      m_sys     = 1'b1;
      m_lck     = 1'b0;
    end else begin
      ls    = m_hist[0];
      m_pll = (m_phase == PH_RESET);
      m_sys = (m_phase != PH_RUN);
      m_lck = (m_phase == PH_RUN);
      m_time++;
      case (m_phase)
        PH_RESET: if (m_time == P_RST) go(PH_WAIT);
        PH_WAIT: begin
          if (ls) go(PH_STABLE);
          else if (m_time == P_TO) begin
            go(PH_RESET);
            if (m_retries < P_RMAX + 1) m_retries++;
          end
        end
        PH_STABLE: begin
          if (!ls) go(PH_WAIT);
          else if (m_time == P_STB) begin
            go(PH_RUN);
            m_retries = 0;
          end
        end
        default: begin
          if (!ls) begin
            go(PH_RESET);
            if (LOSS_EN && m_losses < 255) m_losses++;
          end
        end
      endcase
      if (m_retries > P_RMAX) m_fault = 1'b1;
      void'(m_hist.pop_front());
      m_hist.push_back(e);
    end
    x.pll  = m_pll;
    x.sys  = m_sys;
    x.lck  = m_lck;
    x.flt  = m_fault;
    x.loss = 8'(m_losses);
    exp_q.push_back(x);
  endtask

  task automatic cycle(input bit r, input bit e);
    reset   = r;
    extlock = e;
    model_edge(r, e);
    @(posedge refclk);
    #2;
  endtask

  task automatic hold(input int n, input bit e);
    for (int i = 0; i < n; i++) cycle(1'b0, e);
  endtask

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      if (failures <= 30)
        $display("FAIL %s edge=%0d got=%0d expected=%0d", name, edge_no, act, expv);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge refclk);
      #1;
      edge_no++;
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("pll_rst", int'(pll_rst), int'(x.pll));
        chk("sys_rst", int'(sys_rst), int'(x.sys));
        chk("locked", int'(locked), int'(x.lck));
        chk("fault", int'(fault), int'(x.flt));
        chk("lock_loss_cnt", int'(lock_loss_cnt), int'(x.loss));
      end
    end
  end

  initial begin : driver
    int lvl, len;
    reset   = 1'b1;
    extlock = 1'b0;

    // Bring-up: lock appears 10 edges after reset release.
    hold(0, 1'b0);
    cycle(1'b1, 1'b0); cycle(1'b1, 1'b0);
    hold(10, 1'b0);
    hold(20, 1'b1);

    // Single-cycle loss in RUN.
    hold(1, 1'b0);
    hold(24, 1'b1);

    // Mid-run reset pulse, then re-lock.
    cycle(1'b1, 1'b1);
    hold(24, 1'b1);

    // Glitch during STABLE.
    cycle(1'b1, 1'b0);
    hold(6, 1'b0);
    hold(5, 1'b1);
    hold(1, 1'b0);
    hold(20, 1'b1);

    // Never locks: repeated timeouts, fault, then a late successful lock.
    cycle(1'b1, 1'b0);
    hold(90, 1'b0);
    hold(30, 1'b1);
    hold(1, 1'b0);
    hold(30, 1'b1);

    // Randomised lock waveform with occasional resets.
    for (int k = 0; k < 150; k++) begin
      lvl = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, 30));
      if ($urandom_range(0, 39) == 0) cycle(1'b1, lvl[0]);
      hold(len, lvl[0]);
    end

    // Lock-loss saturation: 300 RUN losses.
    cycle(1'b1, 1'b1);
    hold(30, 1'b1);
    for (int k = 0; k < 300; k++) begin
      hold(1, 1'b0);
      hold(20, 1'b1);
    end
    hold(5, 1'b1);

    drv_done = 1'b1;
  end

  initial begin : finisher
    int waited;
    wait (drv_done);
    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(posedge refclk);
      waited++;
    end
    #5;
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    failures++;
    $display("FAIL watchdog got=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
